ifu_fetch: RTL and testbench
============================

// Module: ifu_fetch
// PURPOSE
//  Instruction fetch stage directly upstream of the decode/control block.
//  Holds the PC and issues one 32-bit instruction fetch at a time over a valid/ready memory port.
//  Presents the returned instruction and its PC to decode with a valid/ready handshake.
//  Handles PC redirects from execute and stops fetching permanently once decode reports ebreak.
// PARAMETERS
//  XLEN      64              PC / address width
//  RESET_PC  64'h8000_0000   PC loaded on reset
// PORTS
//  clk             in   1     clock, all state on rising edge
//  rst_n           in   1     asynchronous, active-low reset
//  imem_req_valid  out  1     fetch request valid
//  imem_req_ready  in   1     memory accepts request
//  imem_req_addr   out  XLEN  fetch address (= pc)
//  imem_rsp_valid  in   1     response data valid (one per accepted request, >=1 cycle later)
//  imem_rsp_data   in   32    fetched instruction
//  inst_valid      out  1     inst/inst_pc valid to decode
//  inst_ready      in   1     decode consumes inst
//  inst            out  32    instruction to decode
//  inst_pc         out  XLEN  PC of inst
//  redirect_valid  in   1     execute redirect (branch/jump)
//  redirect_pc     in   XLEN  redirect target; bits [1:0] ignored (forced 0)
//  halt            in   1     decode ebreak_flag for the inst being presented
//  halted          out  1     fetch stopped
//  fetch_cnt       out  32    count of instructions handed to decode, saturating
// BEHAVIOUR
//  - States: REQ, WAIT, OUT, DROP, HALT. All outputs are decoded from registered state. No
//    combinational input->output paths.
//  - Reset (rst_n=0, async): state=REQ, pc=RESET_PC. inst_valid=0, imem_req_valid=0 until the
//    first edge after release, inst=32'h0, inst_pc=0, halted=0, fetch_cnt=0.
//  - REQ: imem_req_valid=1, imem_req_addr=pc.
//    req_valid&req_ready -> WAIT. Valid is held with a stable address until accepted.
//  - WAIT: on imem_rsp_valid, latch inst<=rsp_data, inst_pc<=pc -> OUT.
//  - OUT: inst_valid=1, inst and inst_pc held stable until the handshake.
//    On inst_valid&inst_ready: pc<=pc+4 (mod 2^XLEN), fetch_cnt++ (sticks at 32'hFFFF_FFFF).
//    Next state is REQ, or HALT if halt=1 that cycle.
//  - Throughput: 1 inst per 3 cycles with zero-wait memory (REQ, WAIT, OUT).
//  - HALT: req_valid=0, inst_valid=0, halted=1. Only exit is reset. Redirect is ignored.
//  - redirect_valid (any non-HALT state) loads pc<=redirect_pc&~3 and overrides pc+4:
//      REQ without handshake -> stay REQ. The new address appears next cycle.
//      REQ with handshake same cycle -> DROP (in-flight request is stale).
//      WAIT, no rsp -> DROP. WAIT with rsp same cycle -> discard data -> REQ.
//      OUT -> REQ, inst_valid=0 next cycle.
//        If inst_ready is high the same cycle, the inst counts as consumed (fetch_cnt++).
//        halt still wins -> HALT.
//      DROP -> stay DROP with the updated pc.
//  - DROP: req_valid=0. On rsp_valid discard data -> REQ.
//  - halt is only sampled in OUT with inst_valid&inst_ready. Elsewhere it is ignored.
//  - Exactly one outstanding memory request at any time. A response is never passed through
//    while a newer redirect is pending.
// TESTING
//  1 Reset release, zero-wait mem returning 32'h00000013 -> req_addr 0x8000_0000,
//    inst_valid on 3rd cycle, next req_addr 0x8000_0004, fetch_cnt=1.
//  2 inst_ready=0 for 5 cycles in OUT -> inst/inst_pc stable, no new request, pc unchanged.
//  3 redirect_valid with redirect_pc=0x8000_0103 while in WAIT, rsp 2 cycles later ->
//    rsp dropped, next req_addr 0x8000_0100, fetch_cnt unchanged.
//  4 redirect coincident with inst handshake in OUT (pc 0x8000_0010, target 0x8000_0040) ->
//    fetch_cnt++, next req_addr 0x8000_0040 (not 0x8000_0014).
//  5 halt=1 with handshake on 32'h00100073 -> halted=1, no further req_valid for 100 cycles,
//    later redirect ignored.
//  6 rst_n asserted mid-WAIT with imem_req_ready randomly stalled -> immediate outputs at reset
//    values, refetch from RESET_PC.

Source files
------------

// File: rtl/ifu_fetch.sv
// rtl/ifu_fetch.sv - single-outstanding instruction fetch stage with redirect and halt
// REQ -> WAIT -> OUT per instruction; DROP swallows the response of a redirected fetch.
module ifu_fetch #(
  parameter int                XLEN     = 64,
  parameter logic [XLEN-1:0]   RESET_PC = 'h8000_0000
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [31:0]     inst,
  output logic [XLEN-1:0] inst_pc,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            halt,
  output logic            halted,
  output logic [31:0]     fetch_cnt
);

  typedef enum logic [2:0] {S_REQ, S_WAIT, S_OUT, S_DROP, S_HALT} state_e;

  state_e          state_q;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] inst_pc_q;
  logic [31:0]     inst_q;
  logic [31:0]     fetch_cnt_q;
  logic            req_valid_q;
  logic            inst_valid_q;
  logic            halted_q;

  logic [XLEN-1:0] redir_pc;
  logic            req_fire;
  logic            inst_fire;

  assign redir_pc  = {redirect_pc[XLEN-1:2], 2'b00};
  assign req_fire  = req_valid_q & imem_req_ready;
  assign inst_fire = inst_valid_q & inst_ready;

  // req_valid_q stays low in the first REQ cycle so no request is visible during reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_REQ;
      pc_q         <= RESET_PC;
      inst_pc_q    <= '0;
      inst_q       <= '0;
      fetch_cnt_q  <= '0;
      req_valid_q  <= 1'b0;
      inst_valid_q <= 1'b0;
      halted_q     <= 1'b0;
    end else begin
      case (state_q)
        S_REQ: begin
          if (redirect_valid) pc_q <= redir_pc;
          if (req_fire) begin
            req_valid_q <= 1'b0;
            state_q     <= redirect_valid ? S_DROP : S_WAIT;
          end else begin
            req_valid_q <= 1'b1;
          end
        end
        S_WAIT: begin
          if (imem_rsp_valid) begin
            if (redirect_valid) begin
              pc_q        <= redir_pc;
              req_valid_q <= 1'b1;
              state_q     <= S_REQ;
            end else begin
              inst_q       <= imem_rsp_data;
              inst_pc_q    <= pc_q;
              inst_valid_q <= 1'b1;
              state_q      <= S_OUT;
            end
          end else if (redirect_valid) begin
            pc_q    <= redir_pc;
            state_q <= S_DROP;
          end
        end
        S_OUT: begin
          if (inst_fire) begin
            if (fetch_cnt_q != 32'hFFFF_FFFF) fetch_cnt_q <= fetch_cnt_q + 32'd1;
            inst_valid_q <= 1'b0;
            if (halt) begin
              halted_q <= 1'b1;
              state_q  <= S_HALT;
            end else begin
              pc_q        <= redirect_valid ? redir_pc : pc_q + XLEN'(4);
              req_valid_q <= 1'b1;
              state_q     <= S_REQ;
            end
          end else if (redirect_valid) begin
            pc_q         <= redir_pc;
            inst_valid_q <= 1'b0;
            req_valid_q  <= 1'b1;
            state_q      <= S_REQ;
          end
        end
        S_DROP: begin
          if (redirect_valid) pc_q <= redir_pc;
          if (imem_rsp_valid) begin
            req_valid_q <= 1'b1;
            state_q     <= S_REQ;
          end
        end
        default: ;
      endcase
    end
  end

  assign imem_req_valid = req_valid_q;
  assign imem_req_addr  = pc_q;
  assign inst_valid     = inst_valid_q;
  assign inst           = inst_q;
  assign inst_pc        = inst_pc_q;
  assign halted         = halted_q;
  assign fetch_cnt      = fetch_cnt_q;

endmodule

// File: tb/tb_ifu_fetch.sv
// tb/tb_ifu_fetch.sv - randomized bench for ifu_fetch against a PC-stream reference model
module tb_ifu_fetch;
  localparam logic [63:0] RESET_PC  = 64'h8000_0000;
  localparam logic [31:0] EBREAK    = 32'h0010_0073;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [63:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [31:0] inst;
  logic [63:0] inst_pc;
  logic        redirect_valid = 1'b0;
  logic [63:0] redirect_pc = '0;
  logic        halt = 1'b0;
  logic        halted;
  logic [31:0] fetch_cnt;

  ifu_fetch dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst), .inst_pc(inst_pc),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .halt(halt), .halted(halted), .fetch_cnt(fetch_cnt)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [63:0] exp_pc;
  logic [31:0] m_cnt;
  logic        m_halt;
  logic        mem_pend;
  int          mem_lat;
  logic [63:0] mem_addr;
  int          lat_lo = 1, lat_hi = 1;
  logic [63:0] halt_addr = 64'h1;
  logic [63:0] last_req_addr;
  int          req_fires;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    if (a == halt_addr) return EBREAK;
    return a[31:0] ^ a[63:32] ^ 32'h0000_0013;
  endfunction

  task automatic step();
    logic        req_fire, inst_fire, p_hold;
    logic [31:0] p_inst;
    logic [63:0] p_pc;
    halt      = inst_valid && (inst == EBREAK);
    req_fire  = imem_req_valid && imem_req_ready;
    inst_fire = inst_valid && inst_ready;
    if (req_fire) begin
      check_eq("req_addr", imem_req_addr, exp_pc);
      check_eq("one_outstanding", {62'b0, mem_pend, imem_rsp_valid}, 64'd0);
      mem_pend      = 1'b1;
      mem_lat       = $urandom_range(lat_hi, lat_lo);
      mem_addr      = imem_req_addr;
      last_req_addr = imem_req_addr;
      req_fires++;
    end
    if (inst_fire) begin
      check_eq("inst_pc", inst_pc, exp_pc);
      check_eq("inst_data", {32'b0, inst}, {32'b0, mem_word(inst_pc)});
    end
    if (inst_valid && imem_req_valid) check_eq("req_during_out", 64'd1, 64'd0);
    if (m_halt) check_eq("halt_quiet", {62'b0, imem_req_valid, inst_valid}, 64'd0);
    if (!m_halt) begin
      if (inst_fire && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
      if (inst_fire && halt) m_halt = 1'b1;
      else if (redirect_valid) exp_pc = {redirect_pc[63:2], 2'b00};
      else if (inst_fire) exp_pc = exp_pc + 64'd4;
    end
    p_hold = inst_valid && !inst_ready && !redirect_valid && !m_halt;
    p_inst = inst;
    p_pc   = inst_pc;
    @(posedge clk);
    @(negedge clk);
    check_eq("fetch_cnt", {32'b0, fetch_cnt}, {32'b0, m_cnt});
    check_eq("halted", {63'b0, halted}, {63'b0, m_halt});
    if (p_hold) begin
      check_eq("hold_valid", {63'b0, inst_valid}, 64'd1);
      check_eq("hold_inst", {32'b0, inst}, {32'b0, p_inst});
      check_eq("hold_pc", inst_pc, p_pc);
    end
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = $urandom;
    if (mem_pend) begin
      mem_lat--;
      if (mem_lat == 0) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = mem_word(mem_addr);
        mem_pend       = 1'b0;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_eq("rst_req_valid", {63'b0, imem_req_valid}, 64'd0);
    check_eq("rst_inst_valid", {63'b0, inst_valid}, 64'd0);
    check_eq("rst_inst", {32'b0, inst}, 64'd0);
    check_eq("rst_inst_pc", inst_pc, 64'd0);
    check_eq("rst_halted", {63'b0, halted}, 64'd0);
    check_eq("rst_fetch_cnt", {32'b0, fetch_cnt}, 64'd0);
    check_eq("rst_addr", imem_req_addr, RESET_PC);
    exp_pc = RESET_PC; m_cnt = 0; m_halt = 0; mem_pend = 0;
    imem_rsp_valid = 0; redirect_valid = 0; halt = 0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check_eq("rel_req_valid", {63'b0, imem_req_valid}, 64'd0);
  endtask

  task automatic run_until_inst();
    int n = 0;
    while (!inst_valid && n < 50) begin step(); n++; end
    check_eq("inst_timeout", {63'b0, inst_valid}, 64'd1);
  endtask

  task automatic run_until_req(output logic [63:0] addr);
    int n = 0;
    int start = req_fires;
    while (req_fires == start && n < 50) begin step(); n++; end
    check_eq("req_timeout", {63'b0, req_fires != start}, 64'd1);
    addr = last_req_addr;
  endtask

  initial begin
    logic [63:0] a;
    logic [31:0] cnt_b;
    int          n;

    // Zero-wait memory: one instruction every three cycles from RESET_PC.
    imem_req_ready = 1; inst_ready = 1; lat_lo = 1; lat_hi = 1;
    do_reset();
    for (int c = 1; c <= 3; c++) begin
      step();
      if (c == 1) check_eq("t1_first_addr", imem_req_valid ? imem_req_addr : 64'hX, RESET_PC);
      check_eq("t1_inst_valid_cycle", {63'b0, inst_valid}, {63'b0, c == 3});
    end
    step();
    check_eq("t1_next_addr", imem_req_valid ? imem_req_addr : 64'hX, RESET_PC + 64'd4);
    check_eq("t1_cnt", {32'b0, fetch_cnt}, 64'd1);

    // Decode back-pressure.
    run_until_inst();
    inst_ready = 0;
    for (int c = 0; c < 5; c++) begin
      step();
      check_eq("t2_no_req", {63'b0, imem_req_valid}, 64'd0);
    end
    check_eq("t2_pc", inst_pc, RESET_PC + 64'd4);
    inst_ready = 1;
    run_until_req(a);
    check_eq("t2_next_addr", a, RESET_PC + 64'd8);

    // Redirect while waiting on memory; the late response must be dropped.
    lat_lo = 2; lat_hi = 2;
    run_until_inst();
    run_until_req(a);
    cnt_b = fetch_cnt;
    redirect_valid = 1; redirect_pc = 64'h8000_0103;
    step();
    redirect_valid = 0;
    run_until_req(a);
    check_eq("t3_addr", a, 64'h8000_0100);
    check_eq("t3_cnt", {32'b0, fetch_cnt}, {32'b0, cnt_b});

    // Redirect coinciding with the decode handshake.
    lat_lo = 1; lat_hi = 1;
    do_reset();
    n = 0;
    while (!(inst_valid && inst_pc == 64'h8000_0010) && n < 80) begin step(); n++; end
    check_eq("t4_reach", inst_pc, 64'h8000_0010);
    redirect_valid = 1; redirect_pc = 64'h8000_0040;
    step();
    redirect_valid = 0;
    check_eq("t4_cnt", {32'b0, fetch_cnt}, 64'd5);
    run_until_req(a);
    check_eq("t4_addr", a, 64'h8000_0040);

    // ebreak halts fetch for good.
    halt_addr = 64'h8000_0008;
    do_reset();
    n = 0;
    while (!halted && n < 40) begin step(); n++; end
    check_eq("t5_halted", {63'b0, halted}, 64'd1);
    check_eq("t5_cnt", {32'b0, fetch_cnt}, 64'd3);
    n = req_fires;
    for (int c = 0; c < 100; c++) begin
      redirect_valid = ($urandom_range(0, 3) == 0);
      redirect_pc    = {32'b0, 32'h8000_0200 + $urandom_range(0, 255)};
      step();
    end
    redirect_valid = 0;
    check_eq("t5_no_req", req_fires - n, 64'd0);
    halt_addr = 64'h1;

    // Reset in the middle of an outstanding fetch with a stalling memory.
    lat_lo = 1; lat_hi = 3;
    do_reset();
    n = 0;
    while (!mem_pend && n < 50) begin
      imem_req_ready = $urandom_range(0, 1);
      step(); n++;
    end
    check_eq("t6_pending", {63'b0, mem_pend}, 64'd1);
    do_reset();
    imem_req_ready = 1;
    run_until_req(a);
    check_eq("t6_refetch", a, RESET_PC);

    // Random traffic: stalls, back-pressure, redirects including address wrap.
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      imem_req_ready = ($urandom_range(0, 3) != 0);
      inst_ready     = ($urandom_range(0, 2) != 0);
      redirect_valid = ($urandom_range(0, 9) == 0);
      redirect_pc    = ($urandom_range(0, 15) == 0) ? 64'hFFFF_FFFF_FFFF_FFFD
                                                    : {32'b0, 32'h8000_0000 + $urandom_range(0, 1023)};
      step();
    end
    check_eq("rand_progress", {63'b0, fetch_cnt > 100}, 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
